// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key expansion sequencer.
package aes_pkg;

  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;
  localparam int NB_ROW = 4;
  localparam int NB_COL = 4;

  // Sequencer states; IDLE is the only state with busy low.
  typedef enum logic [2:0] {
    IDLE,
    SBOX_REQ,
    SBOX_CAP,
    COMMIT,
    RUN,
    DRAIN
  } kx_state_e;

  // Byte (NB_COL*row + col) of a key; byte 0 sits in the most significant lane.
  function automatic logic [7:0] key_byte(input logic [KEY_W-1:0] key,
                                          input int row, input int col);
    return key[KEY_W-1-8*(NB_COL*row+col) -: 8];
  endfunction

  // One key column as a word with row r in bits [8r+7:8r].
  function automatic logic [WORD_W-1:0] key_column(input logic [KEY_W-1:0] key,
                                                   input int col);
    return {key_byte(key, 3, col), key_byte(key, 2, col),
            key_byte(key, 1, col), key_byte(key, 0, col)};
  endfunction

  // Round constant for rounds 1..10; zero elsewhere.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_expansion_ctrl_rot_word.sv
// RotWord of one key column: row1 moves to the bottom lane, row0 to the top.
module rot_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] col_i,
  output logic [WORD_W-1:0] rot_o
);

  // {row3,row2,row1,row0} becomes {row0,row3,row2,row1}.
  assign rot_o = {col_i[7:0], col_i[WORD_W-1:8]};

endmodule

// File: rtl/key_expansion_ctrl.sv
// Key expansion sequencer: drives the shared S-box port and the free-running
// key_shedule column-XOR datapath, and streams round keys 0..NUM_ROUNDS.
module key_expansion_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  cipher_key,
  output logic              busy,
  output logic              done,
  output logic              sbox_req,
  input  logic              sbox_gnt,
  output logic [WORD_W-1:0] sbox_in,
  input  logic [WORD_W-1:0] sbox_out,
  output logic [KEY_W-1:0]  ks_key,
  output logic [WORD_W-1:0] ks_sboxed,
  input  logic              ks_flag,
  input  logic [KEY_W-1:0]  ks_out_key,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [KEY_W-1:0]  rk_data,
  output logic [3:0]        rk_idx
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  kx_state_e         state_q;
  logic [3:0]        round_q;
  logic [WORD_W-1:0] word_q;
  logic              busy_q;
  logic              done_q;
  logic              sbox_req_q;
  logic [WORD_W-1:0] sbox_in_q;
  logic [KEY_W-1:0]  ks_key_q;
  logic [WORD_W-1:0] ks_sboxed_q;
  logic              rk_valid_q;
  logic [KEY_W-1:0]  rk_data_q;
  logic [3:0]        rk_idx_q;

  logic [KEY_W-1:0]  load_key;
  logic [WORD_W-1:0] load_col;
  logic [WORD_W-1:0] rot_next;
  logic              rk_fire;

  // The key about to be loaded: the cipher key on start, otherwise the finished round key.
  assign load_key = (state_q == IDLE) ? cipher_key : ks_out_key;
  assign load_col = key_column(load_key, NB_COL - 1);
  assign rk_fire  = rk_valid_q & rk_ready;

  rot_word u_rot_word (
    .col_i (load_col),
    .rot_o (rot_next)
  );

  // Sequencer with all outputs registered; sbox_in is loaded with the key it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      round_q     <= '0;
      word_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sbox_req_q  <= 1'b0;
      sbox_in_q   <= '0;
      ks_key_q    <= '0;
      ks_sboxed_q <= '0;
      rk_valid_q  <= 1'b0;
      rk_data_q   <= '0;
      rk_idx_q    <= '0;
    end else begin
      done_q <= 1'b0;
      // NOTE: a later non-blocking assignment in this block wins, so a key loaded
      // in the handshake cycle keeps rk_valid high despite this default clear.
      if (rk_fire) rk_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            ks_key_q   <= cipher_key;
            rk_data_q  <= cipher_key;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b1;
            round_q    <= 4'd1;
            sbox_req_q <= 1'b1;
            sbox_in_q  <= rot_next;
            busy_q     <= 1'b1;
            state_q    <= SBOX_REQ;
          end
        end

        SBOX_REQ: begin
          if (sbox_gnt) begin
            sbox_req_q <= 1'b0;
            state_q    <= SBOX_CAP;
          end
        end

        SBOX_CAP: begin
          word_q  <= sbox_out ^ {24'h0, rcon(round_q)};
          state_q <= COMMIT;
        end

        // ks_key is only free to change once the previous key has been taken.
        COMMIT: begin
          if (ks_flag && !rk_valid_q) begin
            ks_sboxed_q <= word_q;
            state_q     <= RUN;
          end
        end

        RUN: begin
          if (ks_flag) begin
            ks_key_q   <= ks_out_key;
            rk_data_q  <= ks_out_key;
            rk_idx_q   <= round_q;
            rk_valid_q <= 1'b1;
            if (round_q == LAST_ROUND) begin
              state_q <= DRAIN;
            end else begin
              round_q    <= round_q + 4'd1;
              sbox_req_q <= 1'b1;
              sbox_in_q  <= rot_next;
              state_q    <= SBOX_REQ;
            end
          end
        end

        DRAIN: begin
          if (rk_fire) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sbox_req  = sbox_req_q;
  assign sbox_in   = sbox_in_q;
  assign ks_key    = ks_key_q;
  assign ks_sboxed = ks_sboxed_q;
  assign rk_valid  = rk_valid_q;
  assign rk_data   = rk_data_q;
  assign rk_idx    = rk_idx_q;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Directed bench for key_expansion_ctrl with S-box, key_shedule and consumer models.
module tb_key_expansion_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] cipher_key;
  logic         busy, done;
  logic         sbox_req, sbox_gnt;
  logic [31:0]  sbox_in, sbox_out;
  logic [127:0] ks_key;
  logic [31:0]  ks_sboxed;
  logic         ks_flag;
  logic [127:0] ks_out_key;
  logic         rk_valid, rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  key_expansion_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .cipher_key(cipher_key),
    .busy(busy), .done(done), .sbox_req(sbox_req), .sbox_gnt(sbox_gnt),
    .sbox_in(sbox_in), .sbox_out(sbox_out), .ks_key(ks_key), .ks_sboxed(ks_sboxed),
    .ks_flag(ks_flag), .ks_out_key(ks_out_key), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_data(rk_data), .rk_idx(rk_idx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- helpers ----------------
  logic [7:0] sbox_tab [256];
  logic [7:0] rc_tab [10];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? (8'(a << 1) ^ 8'h1b) : 8'(a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] k, input int r, input int c);
    return k[127-8*(4*r+c) -: 8];
  endfunction

  function automatic logic [31:0] col_word(input logic [127:0] k, input int c);
    return {byte_of(k, 3, c), byte_of(k, 2, c), byte_of(k, 1, c), byte_of(k, 0, c)};
  endfunction

  // Column-order (FIPS string) <-> row-major layout; the mapping is its own inverse.
  function automatic logic [127:0] transpose(input logic [127:0] k);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*r+c) -: 8] = k[127-8*(4*c+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] assemble(input logic [31:0] a0, input logic [31:0] a1,
                                            input logic [31:0] a2, input logic [31:0] a3);
    logic [31:0]  a [4];
    logic [127:0] o;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*r+c) -: 8] = a[c][8*r +: 8];
    return o;
  endfunction

  // ---------------- reference key expansion (FIPS-197 word form) ----------------
  logic [127:0] ref_keys [11];

  task automatic compute_ref(input logic [127:0] key_rm);
    logic [127:0] ck;
    logic [31:0]  w [44];
    logic [31:0]  t;
    ck = transpose(key_rm);
    for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rc_tab[i/4-1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      ref_keys[r] = transpose({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  // s_boxed_row the datapath needs for round k, recovered from two reference keys.
  function automatic logic [31:0] sb_of(input int k);
    return col_word(ref_keys[k], 0) ^ col_word(ref_keys[k-1], 0);
  endfunction

  // ---------------- S-box port model ----------------
  logic gnt_en;
  assign sbox_gnt = sbox_req & gnt_en;

  // Result is only meaningful the cycle after a grant; filler otherwise.
  always @(posedge clk) begin
    if (sbox_req && sbox_gnt) sbox_out <= sub_word(sbox_in);
    else                      sbox_out <= 32'ha5a5a5a5;
  end

  // ---------------- key_shedule model ----------------
  int          phase = 0;
  logic [31:0] acc [4];

  // Free-running 6-phase column chain: sboxed read at phase 1, key column c at phase c+1.
  always @(posedge clk) begin
    phase <= (phase == 5) ? 0 : phase + 1;
    case (phase)
      1: acc[0] <= col_word(ks_key, 0) ^ ks_sboxed;
      2: acc[1] <= col_word(ks_key, 1) ^ acc[0];
      3: acc[2] <= col_word(ks_key, 2) ^ acc[1];
      4: acc[3] <= col_word(ks_key, 3) ^ acc[2];
      default: ;
    endcase
  end

  assign ks_flag    = (phase == 5);
  assign ks_out_key = ks_flag ? assemble(acc[0], acc[1], acc[2], acc[3]) : {4{32'hdeadbeef}};

  // ---------------- consumer monitor ----------------
  logic [127:0] got_key [16];
  int           got_cnt = 0;
  int           done_cnt = 0;

  // Records every transfer and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rk_valid === 1'b1 && rk_ready === 1'b1) begin
      got_key[rk_idx] = rk_data;
      got_cnt++;
    end
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      128'(busy),      128'(0));
    check({tag, "_done"},      128'(done),      128'(0));
    check({tag, "_sbox_req"},  128'(sbox_req),  128'(0));
    check({tag, "_rk_valid"},  128'(rk_valid),  128'(0));
    check({tag, "_ks_key"},    ks_key,          128'(0));
    check({tag, "_ks_sboxed"}, 128'(ks_sboxed), 128'(0));
    check({tag, "_rk_data"},   rk_data,         128'(0));
    check({tag, "_rk_idx"},    128'(rk_idx),    128'(0));
    check({tag, "_sbox_in"},   128'(sbox_in),   128'(0));
  endtask

  // Full expansion with optional grant withholding, rk stall and a start pulse while busy.
  task automatic run_expansion(input logic [127:0] key, input string tag,
                               input int withhold, input int stall_key, input int restart_at,
                               output logic [31:0] first_sb, output logic [31:0] first_sbin);
    int          base_done, cyc, stall_cnt, stall_bad, unstable, sk;
    logic [31:0] exp_rot, sb_prev;
    logic        sb_seen;
    compute_ref(key);
    exp_rot = {byte_of(key, 0, 3), byte_of(key, 3, 3), byte_of(key, 2, 3), byte_of(key, 1, 3)};
    for (int i = 0; i < 16; i++) got_key[i] = '0;
    got_cnt   = 0;
    base_done = done_cnt;
    stall_cnt = 0; stall_bad = 0; unstable = 0;
    sk        = stall_key + 1;
    sb_prev   = ks_sboxed; sb_seen = 1'b0; first_sb = '0;
    rk_ready  = 1'b1;
    gnt_en    = (withhold == 0);
    cipher_key = key;
    start      = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    first_sbin = sbox_in;
    check({tag, "_k0_valid"}, 128'(rk_valid), 128'(1));
    check({tag, "_k0_idx"},   128'(rk_idx),   128'(0));
    check({tag, "_k0_data"},  rk_data,        key);
    check({tag, "_k0_busy"},  128'(busy),     128'(1));
    check({tag, "_req0"},     128'(sbox_req), 128'(1));
    check({tag, "_sbin0"},    128'(sbox_in),  128'(exp_rot));
    cyc = 0;
    while (done_cnt == base_done && cyc < 3000) begin
      @(posedge clk) #1;
      cyc++;
      if (!sb_seen && ks_sboxed !== sb_prev) begin
        first_sb = ks_sboxed;
        sb_seen  = 1'b1;
      end
      if (cyc < withhold && !(sbox_req === 1'b1 && sbox_in === exp_rot)) unstable++;
      if (cyc == withhold) gnt_en = 1'b1;
      if (cyc == restart_at) begin
        cipher_key = ~key;
        start      = 1'b1;
        @(posedge clk) #1;
        start      = 1'b0;
        cipher_key = key;
        cyc++;
      end
      if (stall_key >= 0) begin
        if (stall_cnt == 0 && got_cnt == stall_key + 1) begin
          rk_ready  = 1'b0;
          stall_cnt = 1;
        end else if (stall_cnt >= 1 && stall_cnt <= 30) begin
          if (rk_valid === 1'b1 &&
              (rk_data !== ref_keys[sk] || rk_idx !== 4'(sk) || ks_sboxed !== sb_of(sk)))
            stall_bad++;
          if (stall_cnt == 30) begin
            check({tag, "_stall_valid"}, 128'(rk_valid), 128'(1));
            check({tag, "_stall_idx"},   128'(rk_idx),   128'(sk));
            rk_ready = 1'b1;
          end
          stall_cnt++;
        end
      end
    end
    check({tag, "_done_seen"}, 128'(done_cnt - base_done), 128'(1));
    if (withhold > 0)  check({tag, "_req_stable"},  128'(unstable),  128'(0));
    if (stall_key >= 0) check({tag, "_stall_hold"}, 128'(stall_bad), 128'(0));
    for (int i = 0; i <= 10; i++)
      check($sformatf("%s_key%0d", tag, i), got_key[i], ref_keys[i]);
    check({tag, "_xfers"}, 128'(got_cnt), 128'(11));
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_idle"},     128'(busy),                  128'(0));
    check({tag, "_one_done"}, 128'(done_cnt - base_done),  128'(1));
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    logic [127:0] key_rm, key2;
    logic [31:0]  fsb, fsbin;
    logic [7:0]   inv, s, pb;
    int           base, cyc;

    // S-box table from GF(2^8) inverse and affine map; Rcon table.
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ 8'h63;
      for (int n = 1; n <= 4; n++) s = s ^ 8'((inv << n) | (inv >> (8 - n)));
      sbox_tab[x] = s;
    end
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    key_rm = transpose(FIPS_KEY);
    key2   = 128'h000102030405060708090a0b0c0d0e0f;

    // Reset state.
    rst = 1'b1; start = 1'b0; cipher_key = '0; rk_ready = 1'b0; gnt_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk) #1;

    // FIPS-197 vector, immediate grants.
    run_expansion(key_rm, "fips", 0, -1, 0, fsb, fsbin);
    check("fips_first_sbox_in", 128'(fsbin), 128'(32'h093c4fcf));
    check("fips_first_sboxed",  128'(fsb),   128'(32'h01eb848b));
    check("fips_key1_const",  got_key[1],  transpose(FIPS_K1));
    check("fips_key10_const", got_key[10], transpose(FIPS_K10));

    // Grant withheld for 20 cycles on the first request.
    run_expansion(key_rm, "withhold", 20, -1, 0, fsb, fsbin);

    // Consumer stalls 30 cycles after key 3.
    run_expansion(key_rm, "stall", 0, 3, 0, fsb, fsbin);

    // Start pulsed with a different key while busy.
    run_expansion(key2, "restart", 0, -1, 30, fsb, fsbin);

    // Reset during RUN of round 5 aborts with no done.
    compute_ref(key2);
    rk_ready = 1'b1; gnt_en = 1'b1;
    base = done_cnt;
    cipher_key = key2; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    cyc = 0;
    while (ks_sboxed !== sb_of(5) && cyc < 1000) begin
      @(posedge clk) #1;
      cyc++;
    end
    check("abort_reached_run5", 128'(ks_sboxed), 128'(sb_of(5)));
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    check_all_zero("abort");
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 128'(done_cnt - base), 128'(0));
    check("abort_idle",    128'(busy),            128'(0));
    run_expansion(key2, "after_abort", 0, -1, 0, fsb, fsbin);

    // Start at each key_shedule phase.
    for (int p = 0; p < 6; p++) begin
      pb = 8'(p * 37 + 5);
      cyc = 0;
      while (phase != p && cyc < 12) begin
        @(posedge clk) #1;
        cyc++;
      end
      check($sformatf("phase%0d_align", p), 128'(phase), 128'(p));
      run_expansion(key2 ^ {16{pb}}, $sformatf("phase%0d", p), 0, -1, 0, fsb, fsbin);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
